// File: rtl/rf_bank_copy_engine_if.sv
// Port set of the banked register-file repository: one write port and two read ports.
// The same bundle is used for the host side and for the repository side of the engine.
interface rf_bank_copy_engine_if;
    logic        we;
    logic [2:0]  sel_write;
    logic [2:0]  sel_read;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [4:0]  wa3;
    logic [31:0] wd3;
    logic [31:0] rd1;
    logic [31:0] rd2;

    modport master (output we, sel_write, sel_read, ra1, ra2, wa3, wd3,
                    input  rd1, rd2);
    modport slave  (input  we, sel_write, sel_read, ra1, ra2, wa3, wd3,
                    output rd1, rd2);
endinterface

// File: rtl/rf_bank_copy_engine.sv
// Bank-to-bank register copy engine for the banked register file; passes the host
// port set through while idle and owns the repository ports while a copy is running.
module rf_bank_copy_engine #(
    parameter int NUM_BANKS = 5,
    parameter int FIRST_REG = 1,
    parameter int PIPE      = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start_i,
    input  logic [2:0]                   src_bank_i,
    input  logic [2:0]                   dst_bank_i,
    input  logic                         abort_i,
    output logic                         busy_o,
    output logic                         done_o,
    output logic                         err_o,
    rf_bank_copy_engine_if.slave         host,
    rf_bank_copy_engine_if.master        rf
);
    typedef enum logic [1:0] {IDLE, COPY, DRAIN, FIN} state_t;

    localparam logic [3:0] NB    = 4'(NUM_BANKS);
    localparam logic [4:0] FIRST = 5'(FIRST_REG);
    localparam logic [4:0] LAST  = 5'd31;

    state_t      state_q, state_d;
    logic [4:0]  idx_q, widx_q;
    logic [2:0]  src_q, dst_q;
    logic [31:0] dreg_q;
    logic        err_q, bad_q;
    logic        legal;

    assign legal = ({1'b0, src_bank_i} < NB) && ({1'b0, dst_bank_i} < NB) &&
                   (src_bank_i != dst_bank_i);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // bad_q turns a rejected command into a one-cycle done pulse without leaving IDLE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q  <= '0;
            widx_q <= '0;
            src_q  <= '0;
            dst_q  <= '0;
            dreg_q <= '0;
            err_q  <= 1'b0;
            bad_q  <= 1'b0;
        end else begin
            bad_q <= 1'b0;
            if (state_q == IDLE && start_i) begin
                if (legal) begin
                    src_q <= src_bank_i;
                    dst_q <= dst_bank_i;
                    idx_q <= FIRST;
                    err_q <= 1'b0;
                end else begin
                    err_q <= 1'b1;
                    bad_q <= 1'b1;
                end
            end else if (state_q == COPY) begin
                idx_q  <= idx_q + 5'd1;
                dreg_q <= rf.rd1;
                widx_q <= idx_q;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i && legal) state_d = COPY;
            COPY: begin
                if (abort_i)              state_d = IDLE;
                else if (idx_q == LAST)   state_d = (PIPE != 0) ? DRAIN : FIN;
            end
            DRAIN:   state_d = abort_i ? IDLE : FIN;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy_o = (state_q != IDLE);
    assign done_o = (state_q == FIN) || bad_q;
    assign err_o  = err_q;

    // Leaving state on the last index keeps the 5-bit wrap from ever reaching a write
    always_comb begin
        rf.we        = host.we;
        rf.sel_write = host.sel_write;
        rf.sel_read  = host.sel_read;
        rf.ra1       = host.ra1;
        rf.ra2       = host.ra2;
        rf.wa3       = host.wa3;
        rf.wd3       = host.wd3;
        host.rd1     = rf.rd1;
        host.rd2     = rf.rd2;
        if (busy_o) begin
            host.rd1     = '0;
            host.rd2     = '0;
            rf.sel_read  = src_q;
            rf.sel_write = dst_q;
            rf.ra1       = idx_q;
            rf.ra2       = idx_q;
            if (PIPE == 0) begin
                rf.wa3 = idx_q;
                rf.wd3 = rf.rd1;
                rf.we  = (state_q == COPY);
            end else begin
                rf.wa3 = widx_q;
                rf.wd3 = dreg_q;
                rf.we  = ((state_q == COPY) && (idx_q != FIRST)) || (state_q == DRAIN);
            end
            if (abort_i) rf.we = 1'b0;
        end
        if (rst) rf.we = 1'b0;
    end
endmodule

// File: tb/tb_rf_bank_copy_engine.sv
// Bench for rf_bank_copy_engine: one PIPE=0 and one PIPE=1 instance, each with its own
// register-file model; expected writes and done pulses are queued and checked by a monitor.
module tb_rf_bank_copy_engine;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  start_v = '0, abort_v = '0, hwe_v = '0;
    logic [1:0]  busy_v, done_v, err_v;
    logic [2:0]  src_s [2], dst_s [2], hsw [2], hsr [2];
    logic [4:0]  hra1 [2], hra2 [2], hwa3 [2];
    logic [31:0] hwd3 [2];

    logic [31:0] mem0 [8][32];
    logic [31:0] mem1 [8][32];

    logic [39:0] wq0 [$], wq1 [$];
    logic [8:0]  dq0 [$], dq1 [$];
    int          n_chk = 0, n_fail = 0;
    int          busy_cnt [2], we_cnt [2];

    logic [1:0]  we_w;
    logic [39:0] wr_w [2];
    logic [31:0] hrd1_w [2], rfrd1_w [2], wd3_w [2];

    rf_bank_copy_engine_if host0 ();
    rf_bank_copy_engine_if host1 ();
    rf_bank_copy_engine_if rf0 ();
    rf_bank_copy_engine_if rf1 ();

    always #5 clk = ~clk;

    assign host0.we = hwe_v[0];  assign host0.sel_write = hsw[0];  assign host0.sel_read = hsr[0];
    assign host0.ra1 = hra1[0];  assign host0.ra2 = hra2[0];       assign host0.wa3 = hwa3[0];
    assign host0.wd3 = hwd3[0];
    assign host1.we = hwe_v[1];  assign host1.sel_write = hsw[1];  assign host1.sel_read = hsr[1];
    assign host1.ra1 = hra1[1];  assign host1.ra2 = hra2[1];       assign host1.wa3 = hwa3[1];
    assign host1.wd3 = hwd3[1];

    assign rf0.rd1 = mem0[rf0.sel_read][rf0.ra1];
    assign rf0.rd2 = mem0[rf0.sel_read][rf0.ra2];
    assign rf1.rd1 = mem1[rf1.sel_read][rf1.ra1];
    assign rf1.rd2 = mem1[rf1.sel_read][rf1.ra2];
    always @(posedge clk) if (rf0.we) mem0[rf0.sel_write][rf0.wa3] <= rf0.wd3;
    always @(posedge clk) if (rf1.we) mem1[rf1.sel_write][rf1.wa3] <= rf1.wd3;

    assign we_w    = {rf1.we, rf0.we};
    assign wr_w[0] = {rf0.sel_write, rf0.wa3, rf0.wd3};
    assign wr_w[1] = {rf1.sel_write, rf1.wa3, rf1.wd3};
    assign hrd1_w[0] = host0.rd1;  assign hrd1_w[1] = host1.rd1;
    assign rfrd1_w[0] = rf0.rd1;   assign rfrd1_w[1] = rf1.rd1;
    assign wd3_w[0] = rf0.wd3;     assign wd3_w[1] = rf1.wd3;

    rf_bank_copy_engine #(.NUM_BANKS(5), .FIRST_REG(1), .PIPE(0)) dut0 (
        .clk(clk), .rst(rst), .start_i(start_v[0]), .src_bank_i(src_s[0]), .dst_bank_i(dst_s[0]),
        .abort_i(abort_v[0]), .busy_o(busy_v[0]), .done_o(done_v[0]), .err_o(err_v[0]),
        .host(host0.slave), .rf(rf0.master));

    rf_bank_copy_engine #(.NUM_BANKS(5), .FIRST_REG(1), .PIPE(1)) dut1 (
        .clk(clk), .rst(rst), .start_i(start_v[1]), .src_bank_i(src_s[1]), .dst_bank_i(dst_s[1]),
        .abort_i(abort_v[1]), .busy_o(busy_v[1]), .done_o(done_v[1]), .err_o(err_v[1]),
        .host(host1.slave), .rf(rf1.master));

    function automatic logic [31:0] preval(input int b, input int i);
        return (b == 0) ? (32'hA000 + 32'(i)) : (32'h1000 * 32'(b) + 32'(i));
    endfunction

    task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_w(input int d, input int b, input int a, input logic [31:0] v);
        if (d == 0) wq0.push_back({3'(b), 5'(a), v});
        else        wq1.push_back({3'(b), 5'(a), v});
    endtask

    task automatic push_d(input int d, input logic e, input int cnt);
        if (d == 0) dq0.push_back({e, 8'(cnt)});
        else        dq1.push_back({e, 8'(cnt)});
    endtask

    task automatic start_copy(input int d, input logic [2:0] s, input logic [2:0] t);
        src_s[d] = s;
        dst_s[d] = t;
        start_v[d] = 1'b1;
        step();
        start_v[d] = 1'b0;
    endtask

    task automatic wait_done(input int d, input int budget);
        int k;
        k = 0;
        while (done_v[d] !== 1'b1 && k < budget) begin
            step();
            k++;
        end
        if (done_v[d] !== 1'b1) begin
            n_chk++;
            n_fail++;
            $display("FAIL done_timeout dut%0d: got no done, expected done within %0d cycles", d, budget);
        end
    endtask

    task automatic mon(input int d);
        logic [39:0] e;
        logic [8:0]  de;
        bit          empty;
        if (busy_v[d] === 1'b1) begin
            busy_cnt[d]++;
            chk($sformatf("h_rd1_busy dut%0d", d), 40'(hrd1_w[d]), 40'd0);
        end
        if (we_w[d] === 1'b1) begin
            we_cnt[d]++;
            empty = (d == 0) ? (wq0.size() == 0) : (wq1.size() == 0);
            if (empty) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_write dut%0d: got %h expected none", d, wr_w[d]);
            end else begin
                if (d == 0) e = wq0.pop_front();
                else        e = wq1.pop_front();
                chk($sformatf("write dut%0d", d), wr_w[d], e);
            end
            if (d == 0 && busy_v[0] === 1'b1)
                chk("pipe0_wd3_eq_rd1", 40'(wd3_w[0]), 40'(rfrd1_w[0]));
        end
        if (done_v[d] === 1'b1) begin
            empty = (d == 0) ? (dq0.size() == 0) : (dq1.size() == 0);
            if (empty) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_done dut%0d: got done expected none", d);
            end else begin
                if (d == 0) de = dq0.pop_front();
                else        de = dq1.pop_front();
                chk($sformatf("done_err_busycycles dut%0d", d),
                    40'({err_v[d], 8'(busy_cnt[d])}), 40'(de));
            end
        end
        if (busy_v[d] !== 1'b1) busy_cnt[d] = 0;
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            src_s[d] = '0; dst_s[d] = '0; hsw[d] = '0; hsr[d] = '0;
            hra1[d] = '0; hra2[d] = '0; hwa3[d] = '0; hwd3[d] = '0;
            busy_cnt[d] = 0; we_cnt[d] = 0;
        end
        fork
            begin
                step();
                step();
                for (int d = 0; d < 2; d++) begin
                    chk("reset_busy", 40'(busy_v[d]), 40'd0);
                    chk("reset_done", 40'(done_v[d]), 40'd0);
                    chk("reset_err", 40'(err_v[d]), 40'd0);
                end
                rst = 1'b0;
                step();

                // preload banks 0..4 of both models through the idle pass-through
                hwe_v = 2'b11;
                for (int b = 0; b < 5; b++) begin
                    for (int i = 0; i < 32; i++) begin
                        for (int d = 0; d < 2; d++) begin
                            hsw[d] = 3'(b); hwa3[d] = 5'(i); hwd3[d] = preval(b, i);
                            push_w(d, b, i, preval(b, i));
                        end
                        step();
                    end
                end
                hwe_v = 2'b00;
                hsr[1] = 3'd1; hra1[1] = 5'd5; hra2[1] = 5'd6;
                #1;
                chk("idle_h_rd1", 40'(host1.rd1), 40'h1005);
                chk("idle_h_rd2", 40'(host1.rd2), 40'h1006);

                // PIPE=1 copy 1->3 with host hammering writes to bank3 r0 while busy
                we_cnt[1] = 0;
                for (int i = 1; i < 32; i++) push_w(1, 3, i, 32'h1000 + 32'(i));
                push_d(1, 1'b0, 33);
                start_copy(1, 3'd1, 3'd3);
                chk("busy_rise_pipe1", 40'(busy_v[1]), 40'd1);
                hwe_v[1] = 1'b1; hsw[1] = 3'd3; hwa3[1] = 5'd0; hwd3[1] = 32'hBAD0_0000;
                wait_done(1, 60);
                hwe_v[1] = 1'b0;
                step();
                step();
                chk("pipe1_write_count", 40'(we_cnt[1]), 40'd31);
                chk("pipe1_r0_untouched", 40'(mem1[3][0]), 40'h3000);
                for (int i = 1; i < 32; i++)
                    chk($sformatf("pipe1_bank3_r%0d", i), 40'(mem1[3][i]), 40'(32'h1000 + 32'(i)));

                // PIPE=0 copy 1->3, abort raised together with start (start wins)
                we_cnt[0] = 0;
                for (int i = 1; i < 32; i++) push_w(0, 3, i, 32'h1000 + 32'(i));
                push_d(0, 1'b0, 32);
                abort_v[0] = 1'b1;
                start_copy(0, 3'd1, 3'd3);
                abort_v[0] = 1'b0;
                chk("start_beats_abort", 40'(busy_v[0]), 40'd1);
                wait_done(0, 60);
                step();
                step();
                chk("pipe0_write_count", 40'(we_cnt[0]), 40'd31);
                chk("pipe0_r0_untouched", 40'(mem0[3][0]), 40'h3000);
                for (int i = 1; i < 32; i++)
                    chk($sformatf("pipe0_bank3_r%0d", i), 40'(mem0[3][i]), 40'(32'h1000 + 32'(i)));

                // illegal commands: same bank, then out-of-range source
                we_cnt[1] = 0;
                push_d(1, 1'b1, 0);
                start_copy(1, 3'd2, 3'd2);
                chk("illegal_same_busy", 40'(busy_v[1]), 40'd0);
                chk("illegal_same_err", 40'(err_v[1]), 40'd1);
                step();
                push_d(1, 1'b1, 0);
                start_copy(1, 3'd5, 3'd0);
                chk("illegal_range_busy", 40'(busy_v[1]), 40'd0);
                step();
                step();
                chk("err_holds", 40'(err_v[1]), 40'd1);
                chk("done_single_pulse", 40'(done_v[1]), 40'd0);
                chk("illegal_no_writes", 40'(we_cnt[1]), 40'd0);

                // PIPE=1 copy 0->4 aborted after the 10th write
                for (int i = 1; i <= 10; i++) push_w(1, 4, i, 32'hA000 + 32'(i));
                start_copy(1, 3'd0, 3'd4);
                chk("accepted_clears_err", 40'(err_v[1]), 40'd0);
                repeat (11) step();
                abort_v[1] = 1'b1;
                step();
                abort_v[1] = 1'b0;
                chk("abort_busy_low", 40'(busy_v[1]), 40'd0);
                step();
                chk("abort_r10", 40'(mem1[4][10]), 40'hA00A);
                chk("abort_r11_kept", 40'(mem1[4][11]), 40'h400B);
                chk("abort_r31_kept", 40'(mem1[4][31]), 40'h401F);
                hwe_v[1] = 1'b1; hsw[1] = 3'd4; hwa3[1] = 5'd5; hwd3[1] = 32'hDEADBEEF;
                push_w(1, 4, 5, 32'hDEADBEEF);
                step();
                hwe_v[1] = 1'b0;
                step();
                chk("host_write_after_abort", 40'(mem1[4][5]), 40'hDEADBEEF);

                // PIPE=0 copy 2->4 hit by reset while idx=20
                for (int i = 1; i <= 19; i++) push_w(0, 4, i, 32'h2000 + 32'(i));
                start_copy(0, 3'd2, 3'd4);
                repeat (19) step();
                rst = 1'b1;
                #1;
                chk("rst_drops_we", 40'(rf0.we), 40'd0);
                chk("rst_busy", 40'(busy_v[0]), 40'd0);
                step();
                rst = 1'b0;
                step();
                chk("post_rst_busy", 40'(busy_v[0]), 40'd0);
                chk("post_rst_done", 40'(done_v[0]), 40'd0);
                chk("post_rst_err", 40'(err_v[0]), 40'd0);
                chk("rst_r1_kept", 40'(mem0[4][1]), 40'h2001);
                chk("rst_r19_kept", 40'(mem0[4][19]), 40'h2013);
                chk("rst_r20_old", 40'(mem0[4][20]), 40'h4014);
                step();
                chk("writes_outstanding_dut0", 40'(wq0.size()), 40'd0);
                chk("writes_outstanding_dut1", 40'(wq1.size()), 40'd0);
                chk("dones_outstanding_dut0", 40'(dq0.size()), 40'd0);
                chk("dones_outstanding_dut1", 40'(dq1.size()), 40'd0);
            end
            begin
                forever begin
                    @(negedge clk);
                    mon(0);
                    mon(1);
                end
            end
        join_any
        disable fork;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
